// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and FSM encoding for the ALU arbiter
// Purpose: ALU control codes recognised as legal and the 2-bit arbiter state encoding.
// Ports: none (package).
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef logic [1:0] alu_arb_state_t;

    localparam alu_arb_state_t ST_IDLE  = 2'b00;
    localparam alu_arb_state_t ST_ISSUE = 2'b01;
    localparam alu_arb_state_t ST_RESP  = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin / fixed-priority grant logic
// Purpose: picks one of two requesters and remembers the last winner.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_req[1:0]    per-port request valid
//   i_en          grants allowed this cycle (owner is idle)
//   o_grant[1:0]  one-hot grant, zero when disabled or no request
//   o_win_id      index of the port that would win
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant,
    output logic       o_win_id
);

    logic r_last_grant;
    logic w_win_id;

    // On a tie the port that did not win last time goes next; otherwise
    // ~i_req[0] selects the only active port (and port 0 on a fixed-priority tie).
    assign w_win_id = (RR_EN && (i_req == 2'b11)) ? ~r_last_grant : ~i_req[0];
    assign o_win_id = w_win_id;

    assign o_grant = !i_en    ? 2'b00 :
                     w_win_id ? {i_req[1], 1'b0} : {1'b0, i_req[0]};

    // A grant is the ready half of a handshake whose valid is already high,
    // so any grant is an accepted request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (|o_grant) begin
            r_last_grant <= w_win_id;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external combinational ALU between two requesters
// Purpose: arbitrates two request channels, registers the winner onto the ALU pins,
//          captures result/zero and returns them on a tagged response channel.
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_req_valid / o_req_ready [1:0] request handshake per port
//   i_req_a, i_req_b, i_req_ctrl    packed per-port operands and control
//   o_alu_a, o_alu_b, o_alu_ctrl    registered drive to the ALU
//   i_alu_res, i_alu_zero           ALU result and zero flag
//   o_rsp_valid / i_rsp_ready       response handshake
//   o_rsp_id, o_rsp_res, o_rsp_zero, o_rsp_err  response payload
//   o_busy                          high whenever not idle
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [2*DATA_W-1:0]   i_req_a,
    input  logic [2*DATA_W-1:0]   i_req_b,
    input  logic [2*CTRL_W-1:0]   i_req_ctrl,
    output logic [DATA_W-1:0]     o_alu_a,
    output logic [DATA_W-1:0]     o_alu_b,
    output logic [CTRL_W-1:0]     o_alu_ctrl,
    input  logic [DATA_W-1:0]     i_alu_res,
    input  logic                  i_alu_zero,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_id,
    output logic [DATA_W-1:0]     o_rsp_res,
    output logic                  o_rsp_zero,
    output logic                  o_rsp_err,
    output logic                  o_busy
);

    alu_arb_state_t    r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_id;
    logic              r_err;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_res;
    logic              r_rsp_zero;

    logic              w_idle;
    logic [1:0]        w_grant;
    logic              w_win_id;
    logic              w_req_hs;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [CTRL_W-1:0] w_sel_ctrl;
    logic              w_legal;

    // Reset gates ready directly so nothing is offered while reset is held.
    assign w_idle = (r_state == ST_IDLE) && !i_rst;

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (i_req_valid),
        .i_en     (w_idle),
        .o_grant  (w_grant),
        .o_win_id (w_win_id)
    );

    assign o_req_ready = w_grant;
    assign w_req_hs    = |w_grant;

    assign w_sel_a    = w_win_id ? i_req_a[DATA_W +: DATA_W]    : i_req_a[0 +: DATA_W];
    assign w_sel_b    = w_win_id ? i_req_b[DATA_W +: DATA_W]    : i_req_b[0 +: DATA_W];
    assign w_sel_ctrl = w_win_id ? i_req_ctrl[CTRL_W +: CTRL_W] : i_req_ctrl[0 +: CTRL_W];

    assign w_legal = (w_sel_ctrl == CTRL_W'(ALU_AND)) ||
                     (w_sel_ctrl == CTRL_W'(ALU_OR))  ||
                     (w_sel_ctrl == CTRL_W'(ALU_ADD)) ||
                     (w_sel_ctrl == CTRL_W'(ALU_SUB));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_ctrl      <= '0;
            r_id        <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_hs) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_ctrl  <= w_sel_ctrl;
                        r_id    <= w_win_id;
                        r_err   <= !w_legal;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_rsp_res   <= i_alu_res;
                    r_rsp_zero  <= i_alu_zero;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    // Going back to IDLE here means the next accept is one cycle later.
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU pins come only from registers, so they hold in IDLE.
    assign o_alu_a     = r_a;
    assign o_alu_b     = r_b;
    assign o_alu_ctrl  = r_ctrl;

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_id;
    assign o_rsp_res   = r_rsp_res;
    assign o_rsp_zero  = r_rsp_zero;
    assign o_rsp_err   = r_err;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter (RR and fixed priority)
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]      req_valid;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic [2*CW-1:0] req_ctrl;
    logic            rsp_ready;

    logic [1:0]    rdy0, rdy1;
    logic [DW-1:0] alu_a0, alu_b0, alu_res0, alu_a1, alu_b1, alu_res1;
    logic [CW-1:0] alu_ctrl0, alu_ctrl1;
    logic          alu_zero0, alu_zero1;
    logic          rsp_valid0, rsp_id0, rsp_zero0, rsp_err0, busy0;
    logic          rsp_valid1, rsp_id1, rsp_zero1, rsp_err1, busy1;
    logic [DW-1:0] rsp_res0, rsp_res1;

    int n_cmp = 0;
    int n_bad = 0;
    bit m_last;

    always #5 clk = ~clk;

    // The external ALU: AND/OR/ADD/SUB, anything else yields 0.
    function automatic logic [DW-1:0] alu_fn(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return '0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [CW-1:0] c);
        return (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0010) || (c == 4'b0110);
    endfunction

    always_comb begin
        alu_res0  = alu_fn(alu_ctrl0, alu_a0, alu_b0);
        alu_zero0 = (alu_res0 == '0);
        alu_res1  = alu_fn(alu_ctrl1, alu_a1, alu_b1);
        alu_zero1 = (alu_res1 == '0);
    end

    alu_arbiter #(.DATA_W(DW), .CTRL_W(CW), .RR_EN(1'b1)) dut_rr (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy0),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_ctrl(req_ctrl),
        .o_alu_a(alu_a0), .o_alu_b(alu_b0), .o_alu_ctrl(alu_ctrl0),
        .i_alu_res(alu_res0), .i_alu_zero(alu_zero0),
        .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id0),
        .o_rsp_res(rsp_res0), .o_rsp_zero(rsp_zero0), .o_rsp_err(rsp_err0), .o_busy(busy0)
    );

    alu_arbiter #(.DATA_W(DW), .CTRL_W(CW), .RR_EN(1'b0)) dut_fp (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy1),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_ctrl(req_ctrl),
        .o_alu_a(alu_a1), .o_alu_b(alu_b1), .o_alu_ctrl(alu_ctrl1),
        .i_alu_res(alu_res1), .i_alu_zero(alu_zero1),
        .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id1),
        .o_rsp_res(rsp_res1), .o_rsp_zero(rsp_zero1), .o_rsp_err(rsp_err1), .o_busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rst_ready", {rdy0, rdy1}, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b00;
        m_last = 1'b1;
        @(negedge clk);
        chk("rst_flags", {rsp_valid0, rsp_id0, rsp_zero0, rsp_err0, busy0,
                          rsp_valid1, rsp_id1, rsp_zero1, rsp_err1, busy1}, 10'd0);
        chk("rst_res", {rsp_res0, rsp_res1}, 64'd0);
        chk("rst_alu", {alu_a0, alu_b0}, 64'd0);
        chk("rst_ctrl", {alu_ctrl0, alu_ctrl1}, 8'd0);
        @(posedge clk); #1;
    endtask

    // One full transaction on both DUTs; entered and left at #1 after a rising edge.
    task automatic run_op(input logic [1:0] vm, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                          input logic [CW-1:0] c0, input logic [DW-1:0] a1,
                          input logic [DW-1:0] b1, input logic [CW-1:0] c1, input int bp);
        bit w0, w1;
        logic [DW-1:0] ea, eb, er, fr;
        logic [CW-1:0] ec, fc;
        logic [DW+3:0] snap;
        w0 = (vm == 2'b11) ? ~m_last : vm[1];
        w1 = vm[0] ? 1'b0 : 1'b1;
        ea = w0 ? a1 : a0;
        eb = w0 ? b1 : b0;
        ec = w0 ? c1 : c0;
        er = alu_fn(ec, ea, eb);
        fc = w1 ? c1 : c0;
        fr = alu_fn(fc, w1 ? a1 : a0, w1 ? b1 : b0);
        req_valid = vm;
        req_a = {a1, a0};
        req_b = {b1, b0};
        req_ctrl = {c1, c0};
        @(negedge clk);
        chk("idle_busy", {busy0, busy1}, 2'b00);
        chk("req_ready_rr", rdy0, w0 ? 2'b10 : 2'b01);
        chk("req_ready_fp", rdy1, w1 ? 2'b10 : 2'b01);
        m_last = w0;
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        req_ctrl = 8'($urandom);
        @(negedge clk);
        chk("issue_state", {busy0, rsp_valid0, rdy0}, 4'b1000);
        chk("issue_alu", {alu_a0, alu_b0}, {ea, eb});
        chk("issue_ctrl", alu_ctrl0, ec);
        @(negedge clk);
        chk("rsp_flags", {rsp_valid0, rsp_id0, rsp_zero0, rsp_err0},
            {1'b1, w0, (er == '0), ~is_legal(ec)});
        chk("rsp_res", rsp_res0, er);
        chk("fp_flags", {rsp_valid1, rsp_id1, rsp_zero1, rsp_err1},
            {1'b1, w1, (fr == '0), ~is_legal(fc)});
        chk("fp_res", rsp_res1, fr);
        snap = {rsp_valid0, rsp_id0, rsp_zero0, rsp_err0, rsp_res0};
        for (int i = 0; i < bp; i++) begin
            req_valid = 2'b11;
            @(negedge clk);
            chk("bp_hold", {rsp_valid0, rsp_id0, rsp_zero0, rsp_err0, rsp_res0}, snap);
            chk("bp_ready", {rdy0, rdy1}, 4'b0000);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid_rr[$];
        int gid_fp[$];
        int gcyc[$];
        logic [1:0] vm;
        logic [CW-1:0] cs [2];
        logic [3:0] legal_tab [4];

        rst = 1'b1;
        req_valid = 2'b00;
        req_a = '0;
        req_b = '0;
        req_ctrl = '0;
        rsp_ready = 1'b0;
        m_last = 1'b1;
        legal_tab[0] = 4'b0000;
        legal_tab[1] = 4'b0001;
        legal_tab[2] = 4'b0010;
        legal_tab[3] = 4'b0110;
        @(posedge clk); #1;
        do_reset();

        run_op(2'b01, 32'd5, 32'd3, 4'b0010, 32'd0, 32'd0, 4'b0000, 0);
        run_op(2'b10, 32'd0, 32'd0, 4'b0000, 32'd7, 32'd7, 4'b0110, 0);
        run_op(2'b01, 32'h1234_5678, 32'h0F0F_0F0F, 4'b0000, 32'd0, 32'd0, 4'b0000, 5);
        run_op(2'b01, 32'd1, 32'd1, 4'b1111, 32'd0, 32'd0, 4'b0000, 0);

        // Reset while in ISSUE
        req_valid = 2'b01;
        req_a = {32'd0, 32'd9};
        req_b = {32'd0, 32'd4};
        req_ctrl = {4'b0000, 4'b0010};
        @(posedge clk); #1;
        req_valid = 2'b00;
        do_reset();
        run_op(2'b10, 32'd0, 32'd0, 4'b0000, 32'hFFFF_FFFF, 32'd1, 4'b0010, 0);

        // Reset while in RESP with the response pending
        req_valid = 2'b10;
        req_a = {32'd6, 32'd0};
        req_b = {32'd3, 32'd0};
        req_ctrl = {4'b0001, 4'b0000};
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        do_reset();
        run_op(2'b01, 32'hF0, 32'h0F, 4'b0001, 32'd0, 32'd0, 4'b0000, 1);

        // Continuous tie after reset
        do_reset();
        req_valid = 2'b11;
        req_a = {32'd10, 32'd20};
        req_b = {32'd1, 32'd2};
        req_ctrl = {4'b0010, 4'b0010};
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rdy0 != 2'b00) begin
                gid_rr.push_back(rdy0[1] ? 1 : 0);
                gcyc.push_back(c);
            end
            if (rdy1 != 2'b00) gid_fp.push_back(rdy1[1] ? 1 : 0);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        m_last = 1'b1;
        chk("tie_count_rr", gid_rr.size(), 4);
        chk("tie_count_fp", gid_fp.size(), 4);
        for (int i = 0; i < gid_rr.size() && i < 4; i++) begin
            chk("tie_order_rr", gid_rr[i], i % 2);
            chk("tie_cycle", gcyc[i], 3 * i);
        end
        for (int i = 0; i < gid_fp.size() && i < 4; i++) chk("tie_order_fp", gid_fp[i], 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            vm = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 5) < 4) cs[p] = legal_tab[$urandom_range(0, 3)];
                else cs[p] = 4'($urandom);
            end
            run_op(vm, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, cs[0],
                   $urandom, $urandom, cs[1], $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
